// File: rtl/blake2s_compress_ctrl.sv
// BLAKE2s compression sequencer.
// Builds the initial working vector from h/IV/t/f and steps an external
// combinational half-round block once per clock, feeding the sigma-permuted
// message words each time. After the last half-round it folds the result
// back into the chaining value and holds it until the consumer takes it.
module blake2s_compress_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] h_i,
    input  logic [511:0] msg_i,
    input  logic [63:0]  t_i,
    input  logic         f_i,
    output logic         rnd_mode_sel,
    output logic [511:0] rnd_v_o,
    output logic [255:0] rnd_m_o,
    input  logic [511:0] rnd_v_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] h_o
);

    localparam logic [4:0]  LAST_CNT = 5'(2 * ROUNDS - 1);
    localparam logic [31:0] IV0 = 32'h6A09E667;
    localparam logic [31:0] IV1 = 32'hBB67AE85;
    localparam logic [31:0] IV2 = 32'h3C6EF372;
    localparam logic [31:0] IV3 = 32'hA54FF53A;
    localparam logic [31:0] IV4 = 32'h510E527F;
    localparam logic [31:0] IV5 = 32'h9B05688C;
    localparam logic [31:0] IV6 = 32'h1F83D9AB;
    localparam logic [31:0] IV7 = 32'h5BE0CD19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [511:0] v_r;
    logic [511:0] msg_r;
    logic [255:0] h_r;
    logic [255:0] h_o_r;
    logic [4:0]   cnt_r;
    logic         out_valid_r;
    logic         in_ready_r;
    logic         last_s;
    logic [511:0] init_v_s;
    logic [63:0]  sigma_row_s;
    logic [3:0]   sel_idx_s;
    logic [255:0] rnd_m_s;

    // One sigma row packed as 16 nibbles, element j at bits [4j+3:4j].
    function automatic logic [63:0] sigma_row(input logic [3:0] r);
        logic [63:0] row;
        case (r)
            4'd0:    row = 64'hFEDCBA9876543210;
            4'd1:    row = 64'h357B20C16DF984AE;
            4'd2:    row = 64'h491763EADF250C8B;
            4'd3:    row = 64'h8F04A562EBCD1397;
            4'd4:    row = 64'hD386CB1EFA427509;
            4'd5:    row = 64'h91EF57D438B0A6C2;
            4'd6:    row = 64'hB8293670A4DEF15C;
            4'd7:    row = 64'hA2684F05931CE7BD;
            4'd8:    row = 64'h5A417D2C803B9EF6;
            4'd9:    row = 64'h0DC3E9BF5167482A;
            default: row = 64'hFEDCBA9876543210;
        endcase
        return row;
    endfunction

    // Final half-round of the block is in flight this cycle.
    always_comb begin
        last_s = (cnt_r == LAST_CNT);
    end

    // Next-state logic for the IDLE -> RUN -> OUT handshake sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Initial working vector: h, then IV with counter and final flag mixed in.
    always_comb begin
        init_v_s             = 512'd0;
        init_v_s[255:0]      = h_i;
        init_v_s[8*32 +: 32]  = IV0;
        init_v_s[9*32 +: 32]  = IV1;
        init_v_s[10*32 +: 32] = IV2;
        init_v_s[11*32 +: 32] = IV3;
        init_v_s[12*32 +: 32] = IV4 ^ t_i[31:0];
        init_v_s[13*32 +: 32] = IV5 ^ t_i[63:32];
        init_v_s[14*32 +: 32] = IV6 ^ {32{f_i}};
        init_v_s[15*32 +: 32] = IV7;
    end

    // Message schedule: row cnt>>1, first or second half of that row by cnt[0].
    always_comb begin
        sigma_row_s = sigma_row(cnt_r[4:1]);
        sel_idx_s   = 4'd0;
        rnd_m_s     = 256'd0;
        for (int k = 0; k < 8; k++) begin
            sel_idx_s            = sigma_row_s[{cnt_r[0], 3'(k), 2'b00} +: 4];
            rnd_m_s[32*k +: 32]  = msg_r[{sel_idx_s, 5'd0} +: 32];
        end
    end

    // Datapath: latch the block, iterate v, fold the result into h'.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r         <= 512'd0;
            msg_r       <= 512'd0;
            h_r         <= 256'd0;
            h_o_r       <= 256'd0;
            cnt_r       <= 5'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        h_r        <= h_i;
                        msg_r      <= msg_i;
                        v_r        <= init_v_s;
                        cnt_r      <= 5'd0;
                        in_ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    v_r <= rnd_v_i;
                    if (last_s) begin
                        h_o_r       <= h_r ^ rnd_v_i[255:0] ^ rnd_v_i[511:256];
                        out_valid_r <= 1'b1;
                        cnt_r       <= 5'd0;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    cnt_r       <= 5'd0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign h_o          = h_o_r;
    assign rnd_mode_sel = cnt_r[0];
    assign rnd_v_o      = v_r;
    assign rnd_m_o      = rnd_m_s;

endmodule

// File: tb/tb_blake2s_compress_ctrl.sv
// Bench for blake2s_compress_ctrl: supplies a behavioural half-round block
// and compares digests with a word-array BLAKE2s compression model.
module tb_blake2s_compress_ctrl;

    localparam int ROUNDS = 10;
    localparam logic [31:0] IV [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                                       32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    localparam int SIGMA [10][16] = '{
        '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
        '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
        '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
        '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
        '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
        '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
        '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
        '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
        '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
        '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};
    localparam int GI [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                                 '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] h_i = 256'd0;
    logic [511:0] msg_i = 512'd0;
    logic [63:0]  t_i = 64'd0;
    logic         f_i = 1'b0;
    logic         rnd_mode_sel;
    logic [511:0] rnd_v_o;
    logic [255:0] rnd_m_o;
    logic [511:0] rnd_v_i;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] h_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    blake2s_compress_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .h_i(h_i), .msg_i(msg_i), .t_i(t_i), .f_i(f_i),
        .rnd_mode_sel(rnd_mode_sel), .rnd_v_o(rnd_v_o), .rnd_m_o(rnd_m_o), .rnd_v_i(rnd_v_i),
        .out_valid(out_valid), .out_ready(out_ready), .h_o(h_o)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // G mixing function; returns {d,c,b,a}.
    function automatic logic [127:0] g_mix(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d,
                                           input logic [31:0] x, input logic [31:0] y);
        a = a + b + x; d = rotr(d ^ a, 16);
        c = c + d;     b = rotr(b ^ c, 12);
        a = a + b + y; d = rotr(d ^ a, 8);
        c = c + d;     b = rotr(b ^ c, 7);
        return {d, c, b, a};
    endfunction

    // Behavioural half-round block as seen by the DUT.
    function automatic logic [511:0] half_round(input logic [511:0] vin, input logic [255:0] mm,
                                                input logic mode);
        logic [31:0]  w [16];
        logic [511:0] res;
        logic [127:0] q;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) w[i] = vin[32*i +: 32];
        for (int j = 0; j < 4; j++) begin
            a = j;
            b = mode ? 4 + ((j + 1) % 4) : 4 + j;
            c = mode ? 8 + ((j + 2) % 4) : 8 + j;
            d = mode ? 12 + ((j + 3) % 4) : 12 + j;
            q = g_mix(w[a], w[b], w[c], w[d], mm[64*j +: 32], mm[64*j+32 +: 32]);
            w[a] = q[31:0]; w[b] = q[63:32]; w[c] = q[95:64]; w[d] = q[127:96];
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = w[i];
        return res;
    endfunction

    always_comb rnd_v_i = half_round(rnd_v_o, rnd_m_o, rnd_mode_sel);

    // Initial working vector of the reference model.
    function automatic logic [511:0] ref_init_v(input logic [255:0] h, input logic [63:0] t,
                                                input logic f);
        logic [511:0] v;
        for (int i = 0; i < 8; i++) begin
            v[32*i +: 32]     = h[32*i +: 32];
            v[32*(i+8) +: 32] = IV[i];
        end
        v[12*32 +: 32] = IV[4] ^ t[31:0];
        v[13*32 +: 32] = IV[5] ^ t[63:32];
        if (f) v[14*32 +: 32] = ~IV[6];
        return v;
    endfunction

    // Full compression F computed on word arrays.
    function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] m,
                                                  input logic [63:0] t, input logic f);
        logic [511:0] vp;
        logic [31:0]  v [16];
        logic [31:0]  mw [16];
        logic [127:0] q;
        logic [255:0] res;
        vp = ref_init_v(h, t, f);
        for (int i = 0; i < 16; i++) begin
            v[i]  = vp[32*i +: 32];
            mw[i] = m[32*i +: 32];
        end
        for (int r = 0; r < ROUNDS; r++) begin
            for (int g = 0; g < 8; g++) begin
                q = g_mix(v[GI[g][0]], v[GI[g][1]], v[GI[g][2]], v[GI[g][3]],
                          mw[SIGMA[r % 10][2*g]], mw[SIGMA[r % 10][2*g+1]]);
                v[GI[g][0]] = q[31:0];  v[GI[g][1]] = q[63:32];
                v[GI[g][2]] = q[95:64]; v[GI[g][3]] = q[127:96];
            end
        end
        for (int i = 0; i < 8; i++) res[32*i +: 32] = h[32*i +: 32] ^ v[i] ^ v[i+8];
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] x;
        for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
        return x;
    endfunction

    function automatic logic [511:0] rand512();
        return {rand256(), rand256()};
    endfunction

    // Present a block just after a falling edge; returns at the falling edge with cnt=0.
    task automatic start_block(input logic [255:0] h, input logic [511:0] m,
                               input logic [63:0] t, input logic f);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL start_in_ready: got %b expected 1", in_ready);
        end
        h_i = h; msg_i = m; t_i = t; f_i = f; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        h_i = rand256(); msg_i = rand512(); t_i = {$urandom, $urandom}; f_i = $urandom_range(0, 1);
    endtask

    // Wait (bounded) for out_valid and check the number of rising edges taken.
    task automatic wait_out(input int exp_edges);
        int edges;
        edges = 0;
        while (out_valid !== 1'b1 && edges < 60) begin
            @(posedge clk); edges++; @(negedge clk);
        end
        n_checks++;
        if (edges != exp_edges) begin
            n_fail++; $display("FAIL latency: got %0d edges expected %0d", edges, exp_edges);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic run_block(input string name, input logic [255:0] h, input logic [511:0] m,
                             input logic [63:0] t, input logic f);
        logic [255:0] exp_h;
        exp_h = ref_compress(h, m, t, f);
        start_block(h, m, t, f);
        wait_out(2 * ROUNDS);
        n_checks++;
        if (h_o !== exp_h) begin
            n_fail++; $display("FAIL %s digest: got %h expected %h", name, h_o, exp_h);
        end
        handshake();
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || h_o !== 256'd0 || rnd_mode_sel !== 1'b0 ||
            rnd_v_o !== 512'd0 || rnd_m_o !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b mode=%b h_o=%h expected 1/0/0/0",
                     in_ready, out_valid, rnd_mode_sel, h_o);
        end
    endtask

    task automatic test_abc();
        logic [255:0] h;
        logic [255:0] be;
        logic [255:0] exp_h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = IV[i];
        h[31:0] = h[31:0] ^ 32'h01010020;
        be = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
        for (int i = 0; i < 32; i++) exp_h[8*i +: 8] = be[255 - 8*i -: 8];
        start_block(h, 512'h636261, 64'd3, 1'b1);
        wait_out(2 * ROUNDS);
        n_checks++;
        if (h_o !== exp_h) begin
            n_fail++; $display("FAIL abc digest: got %h expected %h", h_o, exp_h);
        end
        n_checks++;
        if (h_o !== ref_compress(h, 512'h636261, 64'd3, 1'b1)) begin
            n_fail++; $display("FAIL abc model: got %h expected %h", h_o,
                               ref_compress(h, 512'h636261, 64'd3, 1'b1));
        end
        handshake();
    endtask

    task automatic test_schedule();
        logic [511:0] m;
        logic [255:0] h;
        logic [255:0] exp_m;
        h = rand256();
        for (int k = 0; k < 16; k++) m[32*k +: 32] = 32'(k);
        start_block(h, m, 64'd64, 1'b0);
        n_checks++;
        if (rnd_v_o !== ref_init_v(h, 64'd64, 1'b0)) begin
            n_fail++; $display("FAIL init_v: got %h expected %h", rnd_v_o, ref_init_v(h, 64'd64, 1'b0));
        end
        for (int c = 0; c < 2 * ROUNDS; c++) begin
            for (int k = 0; k < 8; k++) exp_m[32*k +: 32] = 32'(SIGMA[c / 2][8 * (c % 2) + k]);
            n_checks++;
            if (rnd_m_o !== exp_m || rnd_mode_sel !== 1'((c % 2))) begin
                n_fail++;
                $display("FAIL schedule cnt%0d: got m=%h mode=%b expected m=%h mode=%0d",
                         c, rnd_m_o, rnd_mode_sel, exp_m, c % 2);
            end
            if (c < 2 * ROUNDS - 1) begin
                @(posedge clk); @(negedge clk);
            end
        end
        wait_out(1);
        n_checks++;
        if (h_o !== ref_compress(h, m, 64'd64, 1'b0)) begin
            n_fail++; $display("FAIL schedule digest: got %h expected %h", h_o,
                               ref_compress(h, m, 64'd64, 1'b0));
        end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [255:0] h;
        logic [511:0] m;
        logic [255:0] held;
        h = rand256(); m = rand512();
        out_ready = 1'b0;
        start_block(h, m, 64'd200, 1'b1);
        wait_out(2 * ROUNDS);
        held = ref_compress(h, m, 64'd200, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; h_i = rand256(); msg_i = rand512();
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (h_o !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure hold %0d: got h_o=%h ov=%b ir=%b expected %h/1/0",
                         i, h_o, out_valid, in_ready, held);
            end
        end
        in_valid = 1'b0;
        handshake();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ignored_in_valid: got ov=%b ir=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] h0;
        logic [255:0] d1;
        logic [511:0] m1;
        logic [511:0] m2;
        for (int i = 0; i < 8; i++) h0[32*i +: 32] = IV[i];
        h0[31:0] = h0[31:0] ^ 32'h01010020;
        m1 = rand512(); m2 = rand512();
        d1 = ref_compress(h0, m1, 64'd64, 1'b0);
        run_block("b2b_first", h0, m1, 64'd64, 1'b0);
        run_block("b2b_second", d1, m2, 64'd128, 1'b1);
    endtask

    task automatic test_async_reset();
        logic quiet;
        start_block(rand256(), rand512(), 64'd5, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (rnd_mode_sel !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL pre_reset_run: got mode=%b ir=%b expected 1/0", rnd_mode_sel, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || h_o !== 256'd0 || rnd_mode_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got ir=%b ov=%b mode=%b h_o=%h expected 1/0/0/0",
                     in_ready, out_valid, rnd_mode_sel, h_o);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        quiet = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++; $display("FAIL aborted_block_output: got out_valid pulse expected none");
        end
        run_block("after_reset", rand256(), rand512(), 64'd77, 1'b1);
    endtask

    task automatic test_final_flag();
        logic [255:0] h;
        logic [511:0] m;
        logic [63:0]  t;
        logic [31:0]  v14 [2];
        logic [255:0] d [2];
        h = rand256(); m = rand512(); t = {$urandom, $urandom};
        for (int f = 0; f < 2; f++) begin
            start_block(h, m, t, 1'(f));
            v14[f] = rnd_v_o[14*32 +: 32];
            wait_out(2 * ROUNDS);
            d[f] = h_o;
            n_checks++;
            if (h_o !== ref_compress(h, m, t, 1'(f))) begin
                n_fail++; $display("FAIL final_flag f=%0d digest: got %h expected %h", f, h_o,
                                   ref_compress(h, m, t, 1'(f)));
            end
            handshake();
        end
        n_checks++;
        if ((v14[0] ^ v14[1]) !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL final_flag v14: got xor %h expected ffffffff", v14[0] ^ v14[1]);
        end
        n_checks++;
        if (d[0] === d[1]) begin
            n_fail++; $display("FAIL final_flag outputs: got equal digests %h expected different", d[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_block("random", rand256(), rand512(), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_abc();
        test_schedule();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_final_flag();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
